// File: rtl/debug_link_pkg.sv
// Shared definitions for the NeXT ASIC debug link (transmitter and receiver).
package debug_link_pkg;

    localparam int DEBUG_FRAME_WIDTH = 40;
    localparam int DEBUG_GAP_DEFAULT = 5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        PARITY,
        GAP
    } tx_state_t;

endpackage

// File: rtl/debug_tx_holdbuf.sv
// One-entry valid/ready holding buffer in front of the debug link serializer.
module debug_tx_holdbuf
    import debug_link_pkg::*;
#(
    parameter int WIDTH = DEBUG_FRAME_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             unload_i,
    output logic [WIDTH-1:0] hold_data_o,
    output logic             hold_full_o
);

    logic [WIDTH-1:0] hold_q, hold_d;
    logic             full_q, full_d;
    logic             load;

    always_comb begin
        load   = in_valid & ~full_q;
        hold_d = load ? in_data : hold_q;
        full_d = load | (full_q & ~unload_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end

    assign in_ready    = ~full_q;
    assign hold_data_o = hold_q;
    assign hold_full_o = full_q;

endmodule

// File: rtl/debug_data_transmitter.sv
// Debug link serializer: data_start strobe, MSB-first payload, idle gap.
// Define DEBUG_TX_PARITY_EN to append an odd parity bit to every frame.
module debug_data_transmitter
    import debug_link_pkg::*;
#(
    parameter int WIDTH      = DEBUG_FRAME_WIDTH,
    parameter int GAP_CYCLES = DEBUG_GAP_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data_start,
    output logic             sout,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       gap_q, gap_d;
    logic             par_q, par_d;
    logic             sout_q, sout_d;
    logic             ds_q, ds_d;
    logic             fd_q, fd_d;

    logic             unload;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;

    debug_tx_holdbuf #(
        .WIDTH(WIDTH)
    ) u_holdbuf (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .unload_i   (unload),
        .hold_data_o(hold_data),
        .hold_full_o(hold_full)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        par_d   = par_q;
        unload  = 1'b0;
        fd_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hold_full) begin
                    unload  = 1'b1;
                    shift_d = hold_data;
                    par_d   = ~^hold_data;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = CW'(WIDTH - 1);
                state_d = SHIFT;
            end
            SHIFT: begin
                shift_d = shift_q << 1;
                if (cnt_q == '0) begin
                    gap_d = 8'(GAP_CYCLES - 1);
`ifdef DEBUG_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = GAP;
                    fd_d    = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PARITY: begin
                state_d = GAP;
                fd_d    = 1'b1;
            end
            GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin values are computed from the next state so they leave a flop.
        ds_d = (state_d == START);
        if (state_d == SHIFT) begin
            sout_d = shift_d[WIDTH-1];
        end else if (state_d == PARITY) begin
            sout_d = par_d;
        end else begin
            sout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            gap_q   <= 8'd0;
            par_q   <= 1'b0;
            sout_q  <= 1'b0;
            ds_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            par_q   <= par_d;
            sout_q  <= sout_d;
            ds_q    <= ds_d;
            fd_q    <= fd_d;
        end
    end

    assign data_start = ds_q;
    assign sout       = sout_q;
    assign frame_done = fd_q;
    assign busy       = (state_q != IDLE) | hold_full;

endmodule

// File: doc/debug_data_transmitter.md
Name: debug_data_transmitter

Overview:
- Upstream serializer feeding DebugDataReceiver on the NeXT ASIC debug link.
- Accepts 40-bit words over a valid/ready handshake and buffers one word while another is being sent.
- Each frame is one data_start cycle followed by WIDTH serial bits, MSB first, then a programmable idle gap.
- Produces the exact pin-level format DebugDataReceiver expects.

Parameters:
- WIDTH, 40, frame payload width in bits.
- GAP_CYCLES, 5, minimum sout-low, data_start-low cycles after the last bit before the next data_start; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  one-entry holding buffer is empty; transfer occurs when in_valid & in_ready at a clk edge.
- data_start  output  1  frame start strobe to the receiver.
- sout  output  1  serial data to the receiver.
- busy  output  1  state is not IDLE or the holding buffer is full.
- frame_done  output  1  one-cycle pulse in the cycle after the last payload bit (or parity bit) is driven.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=IDLE, holding buffer empty.
  - in_ready=1, data_start=0, sout=0, busy=0, frame_done=0.
  - Shift register and bit counter cleared.
  - Reset mid-frame aborts the frame immediately; no partial completion, no frame_done.
- Holding buffer (hold_reg, hold_full):
  - Loaded on in_valid & in_ready; in_ready = !hold_full (registered).
  - Emptied when the FSM moves the word into the shift register.
  - Load and unload on the same edge: the new word is captured and hold_full stays 1.
- FSM states IDLE, START, SHIFT, GAP:
  - IDLE: sout=0, data_start=0. If hold_full, move hold_reg to the shift register, clear hold_full, go to START.
  - START (exactly 1 cycle): data_start=1, sout=0. Go to SHIFT with bit counter = WIDTH-1.
  - SHIFT (WIDTH cycles): sout = shift register MSB, data_start=0. Shift left each cycle. When the counter reaches 0, go to GAP and pulse frame_done on the next cycle.
  - GAP: sout=0, data_start=0 for GAP_CYCLES cycles, then IDLE.
- Latency:
  - Handshake at edge T with the FSM idle and buffer empty: hold_full=1 after T; IDLE transfers at T+1; data_start high during cycle T+1..T+2; first bit during T+2..T+3.
  - So data_start follows the accepting edge by one cycle; first bit follows data_start by one cycle.
- Back-to-back frames: a word accepted during SHIFT or GAP starts exactly GAP_CYCLES+1 cycles after the last payload bit (the gap plus one IDLE cycle). No frames are lost.
- Outputs sout, data_start and frame_done are registered, with no combinational path from in_valid.
- in_data is sampled only on handshake; later changes are ignored.
- in_valid is sampled only when in_ready=1; a dropped in_valid without handshake leaves no effect.

Optional Feature:
- Macro DEBUG_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted after SHIFT for 1 cycle; sout = odd parity over the WIDTH payload bits (XOR of payload, inverted).
  - frame_done pulses after the parity cycle.
  - Frame length is WIDTH+1 bit cycles.
- When undefined: no PARITY state; frame is exactly WIDTH bit cycles.

Decomposition:
- Shared package debug_link_pkg:
  - DEBUG_FRAME_WIDTH=40.
  - DEBUG_GAP_DEFAULT=5.
  - State enum tx_state_t {IDLE, START, SHIFT, PARITY, GAP}.
  - Used also by DebugDataReceiver.
- One natural sub-module: debug_tx_holdbuf, containing the one-entry valid/ready buffer with hold_reg, hold_full and in_ready.
- The FSM, shift register and counters stay in the top module.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert reset during bit 20 of a frame.
  - Response: next cycle sout=0, data_start=0, in_ready=1, busy=0; no frame_done; next accepted word starts a clean frame.
- Single word:
  - Stimulus: send in_data=40'hA5F0AAAAA9 with one-cycle in_valid.
  - Response: data_start high for exactly 1 cycle, one cycle after the handshake edge. sout then shows the bit sequence 1010_0101_1111_0000_1010…1010_1001 MSB first. frame_done pulses once. sout stays 0 for ≥5 cycles.
- Back-to-back:
  - Stimulus: hold in_valid=1 with words 40'h0000000001 then 40'h8000000000.
  - Response: the second word is accepted during the first frame; its data_start occurs exactly 6 cycles after the first frame's last bit; both payloads are intact.
- Backpressure:
  - Stimulus: offer a third word while hold_full=1.
  - Response: in_ready=0 and no capture; the word is accepted only after the FSM unloads the buffer. in_data toggling while in_ready=0 does not corrupt the transmitted data.
- Loopback:
  - Stimulus: connect data_start/sout to DebugDataReceiver and send 40'h123456789A and 40'hFFFFFFFFFF.
  - Response: the receiver data equals each word, with out_valid asserted once per frame.
- Parity (DEBUG_TX_PARITY_EN defined):
  - Stimulus: send 40'h0000000001.
  - Response: bit 41 on sout is 0.
  - Stimulus: send 40'h0000000000.
  - Response: parity bit is 1; frame_done follows the parity cycle.
